// File: rtl/des_ip_loader_if.sv
// ----------------------------------------------------------------------------
// des_ip_loader_if : beat-stream input and L0/R0 output bundle of the loader.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface des_ip_loader_if #(
  parameter int WORD_WIDTH = 16
);
  logic                  in_flush;
  logic [WORD_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [31:0]           out_l;
  logic [31:0]           out_r;
  logic                  out_valid;
  logic                  out_ready;
  logic                  partial;

  modport master (
    output in_flush, in_data, in_valid, out_ready,
    input  in_ready, out_l, out_r, out_valid, partial
  );

  modport slave (
    input  in_flush, in_data, in_valid, out_ready,
    output in_ready, out_l, out_r, out_valid, partial
  );
endinterface

`default_nettype wire

// File: rtl/des_ip_loader.sv
// ----------------------------------------------------------------------------
// des_ip_loader : assembles 64-bit blocks from beats, applies DES IP, 2-deep FIFO.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module des_ip_loader #(
  parameter int WORD_WIDTH = 16
) (
  input  logic              CLK,
  input  logic              RST,
  des_ip_loader_if.slave    bus
);

  localparam int BEATS = 64 / WORD_WIDTH;
  localparam int CW    = $clog2(BEATS);
  localparam int C_IP_OFS [8] = '{24, 56, 16, 48, 8, 40, 0, 32};

  // IP as a pure wiring permutation; loops unroll to constant bit moves.
  function automatic logic [63:0] des_ip(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        y[r + C_IP_OFS[c]] = x[63 - 8*r - c];
      end
    end
    return y;
  endfunction

  logic [CW-1:0] cnt_q,  cnt_d;
  logic [63:0]   asm_q,  asm_d;
  logic [1:0]    fcnt_q, fcnt_d;
  logic [63:0]   head_q, head_d;
  logic [63:0]   tail_q, tail_d;

  logic          w_in_ready;
  logic          w_accept;
  logic          w_last;
  logic          w_push;
  logic          w_pop;
  logic [63:0]   w_block;
  logic [63:0]   w_ip;

  assign w_in_ready = (fcnt_q != 2'd2);
  assign w_accept   = bus.in_valid && w_in_ready && !bus.in_flush;
  assign w_last     = (cnt_q == CW'(BEATS - 1));
  assign w_push     = w_accept && w_last;
  assign w_pop      = (fcnt_q != 2'd0) && bus.out_ready;

  always_comb begin
    w_block = asm_q;
    w_block[WORD_WIDTH-1:0] = bus.in_data;
  end

  assign w_ip = des_ip(w_block);

  always_comb begin
    cnt_d = cnt_q;
    asm_d = asm_q;
    if (bus.in_flush) begin
      cnt_d = '0;
    end else if (w_accept) begin
      for (int k = 0; k < BEATS; k++) begin
        if (cnt_q == CW'(k)) begin
          asm_d[63 - k*WORD_WIDTH -: WORD_WIDTH] = bus.in_data;
        end
      end
      cnt_d = w_last ? '0 : cnt_q + CW'(1);
    end
  end

  // A push never coincides with a full FIFO because in_ready gates it.
  always_comb begin
    fcnt_d = fcnt_q;
    head_d = head_q;
    tail_d = tail_q;
    case ({w_push, w_pop})
      2'b10: begin
        if (fcnt_q == 2'd0) head_d = w_ip;
        else                tail_d = w_ip;
        fcnt_d = fcnt_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        fcnt_d = fcnt_q - 2'd1;
      end
      2'b11: begin
        if (fcnt_q == 2'd1) begin
          head_d = w_ip;
        end else begin
          head_d = tail_q;
          tail_d = w_ip;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q  <= '0;
      asm_q  <= '0;
      fcnt_q <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      asm_q  <= asm_d;
      fcnt_q <= fcnt_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (fcnt_q != 2'd0);
  assign bus.out_l     = head_q[63:32];
  assign bus.out_r     = head_q[31:0];
  assign bus.partial   = (cnt_q != '0);

endmodule

`default_nettype wire

// File: tb/tb_des_ip_loader.sv
// ----------------------------------------------------------------------------
// tb_des_ip_loader : randomized scoreboard bench using the DES IP/FP tables.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_des_ip_loader;

  localparam int W     = 16;
  localparam int BEATS = 64 / W;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  des_ip_loader_if #(.WORD_WIDTH(W))  bus ();
  des_ip_loader_if #(.WORD_WIDTH(8))  b8  ();
  des_ip_loader_if #(.WORD_WIDTH(32)) b32 ();

  des_ip_loader #(.WORD_WIDTH(W))  dut   (.CLK(CLK), .RST(RST), .bus(bus));
  des_ip_loader #(.WORD_WIDTH(8))  dut8  (.CLK(CLK), .RST(RST), .bus(b8));
  des_ip_loader #(.WORD_WIDTH(32)) dut32 (.CLK(CLK), .RST(RST), .bus(b32));

  // Standard DES tables: output DES bit i takes input DES bit T[i-1].
  int IPT [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                   62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                   57,49,41,33,25,17, 9,1, 59,51,43,35,27,19,11,3,
                   61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  int FPT [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                   38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                   36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                   34,2,42,10,50,18,58,26, 33,1,41, 9,49,17,57,25};

  function automatic logic [63:0] perm(input logic [63:0] x, input bit use_ip);
    logic [63:0] y;
    for (int i = 1; i <= 64; i++)
      y[64 - i] = x[64 - (use_ip ? IPT[i-1] : FPT[i-1])];
    return y;
  endfunction

  int          checks   = 0;
  int          failures = 0;
  int          pops     = 0;
  logic [63:0] exp_q [$];
  logic [63:0] blk_q [$];
  bit          rand_ready = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic send_beat(input logic [W-1:0] d, input bit last, input logic [63:0] blk);
    int t;
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    t = 0;
    while (!bus.in_ready && t < 200) begin
      @(negedge CLK);
      t++;
    end
    if (!bus.in_ready) begin
      chk("stall_timeout", 64'd1, 64'd0);
    end else if (last) begin
      exp_q.push_back(perm(blk, 1'b1));
      blk_q.push_back(blk);
    end
    @(negedge CLK);
    bus.in_valid = 1'b0;
  endtask

  task automatic send_block(input logic [63:0] blk, input int gapmax);
    logic [63:0] v;
    v = blk;
    for (int k = 0; k < BEATS; k++) begin
      send_beat(v[63 - k*W -: W], k == BEATS - 1, blk);
      if (gapmax > 0) repeat ($urandom_range(0, gapmax)) @(negedge CLK);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(negedge CLK);
      t++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic check_vec(input string name, input logic [63:0] blk, input logic [63:0] lr);
    send_block(blk, 0);
    #1;
    chk({name, "_valid"}, bus.out_valid, 1);
    chk({name, "_lr"}, {bus.out_l, bus.out_r}, lr);
    @(negedge CLK);
  endtask

  always @(negedge CLK)
    if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);

  // Monitor: pops the scoreboard on every handshake; also checks output hold.
  bit          hold = 1'b0;
  logic [63:0] held;
  initial begin
    logic [63:0] e, b, got;
    forever begin
      @(negedge CLK);
      #1;
      if (RST) begin
        hold = 1'b0;
        continue;
      end
      if (hold) begin
        chk("hold_valid", bus.out_valid, 1);
        chk("hold_data", {bus.out_l, bus.out_r}, held);
      end
      if (bus.out_valid && bus.out_ready) begin
        pops++;
        got = {bus.out_l, bus.out_r};
        if (exp_q.size() == 0) begin
          chk("unexpected_output", got, 64'hx);
        end else begin
          e = exp_q.pop_front();
          b = blk_q.pop_front();
          chk("sb_ip", got, e);
          chk("sb_fp_inverse", perm(got, 1'b0), b);
        end
      end
      hold = bus.out_valid && !bus.out_ready;
      held = {bus.out_l, bus.out_r};
    end
  end

  initial begin
    logic [63:0] vec, a, bb, c;
    int p0;
    bus.in_flush = 0; bus.in_valid = 0; bus.in_data = '0; bus.out_ready = 1;
    b8.in_flush  = 0; b8.in_valid  = 0; b8.in_data  = '0; b8.out_ready  = 1;
    b32.in_flush = 0; b32.in_valid = 0; b32.in_data = '0; b32.out_ready = 1;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_partial", bus.partial, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_lr", {bus.out_l, bus.out_r}, 64'h0);
    @(negedge CLK);

    check_vec("vec16", 64'h0123456789ABCDEF, 64'hCC00CCFF_F0AAF0AA);
    check_vec("zeros", 64'h0, 64'h0);
    check_vec("ones", 64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFF);
    drain();

    vec = 64'h0123456789ABCDEF;
    for (int i = 0; i < 2; i++) begin
      b32.in_valid = 1; b32.in_data = vec[63 - 32*i -: 32];
      @(negedge CLK);
    end
    b32.in_valid = 0;
    #1;
    chk("w32_valid", b32.out_valid, 1);
    chk("w32_lr", {b32.out_l, b32.out_r}, 64'hCC00CCFF_F0AAF0AA);
    @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      b8.in_valid = 1; b8.in_data = vec[63 - 8*i -: 8];
      @(negedge CLK);
    end
    b8.in_valid = 0;
    #1;
    chk("w8_valid", b8.out_valid, 1);
    chk("w8_lr", {b8.out_l, b8.out_r}, 64'hCC00CCFF_F0AAF0AA);
    @(negedge CLK);

    // Back-pressure: two blocks fill the FIFO, third must stall on its first beat.
    bus.out_ready = 0;
    a  = {$urandom, $urandom};
    bb = {$urandom, $urandom};
    c  = {$urandom, $urandom};
    send_block(a, 0);
    send_block(bb, 0);
    #1;
    chk("full_in_ready", bus.in_ready, 0);
    chk("full_out_valid", bus.out_valid, 1);
    fork
      send_block(c, 0);
    join_none
    repeat (3) begin
      @(negedge CLK);
      #1;
      chk("stall_partial", bus.partial, 0);
      chk("stall_in_ready", bus.in_ready, 0);
    end
    @(negedge CLK);
    bus.out_ready = 1;
    @(negedge CLK);
    bus.out_ready = 0;
    #1;
    chk("pop_from_full_in_ready", bus.in_ready, 1);
    @(negedge CLK);
    rand_ready = 1;
    wait fork;
    drain();

    // Flush mid-block with a beat in the same cycle.
    rand_ready = 0;
    @(negedge CLK);
    bus.out_ready = 1;
    p0 = pops;
    send_beat(W'($urandom), 0, 64'h0);
    send_beat(W'($urandom), 0, 64'h0);
    #1;
    chk("pre_flush_partial", bus.partial, 1);
    @(negedge CLK);
    bus.in_flush = 1; bus.in_valid = 1; bus.in_data = W'($urandom);
    @(negedge CLK);
    bus.in_flush = 0; bus.in_valid = 0;
    #1;
    chk("post_flush_partial", bus.partial, 0);
    @(negedge CLK);
    send_block({$urandom, $urandom}, 0);
    drain();
    repeat (3) @(negedge CLK);
    chk("flush_one_output", pops - p0, 1);

    // Asynchronous reset mid-block with one entry buffered.
    bus.out_ready = 0;
    send_block({$urandom, $urandom}, 0);
    send_beat(W'($urandom), 0, 64'h0);
    send_beat(W'($urandom), 0, 64'h0);
    #2;
    RST = 1'b1;
    #1;
    chk("arst_out_valid", bus.out_valid, 0);
    chk("arst_partial", bus.partial, 0);
    chk("arst_in_ready", bus.in_ready, 1);
    exp_q.delete();
    blk_q.delete();
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    bus.out_ready = 1;
    @(negedge CLK);
    check_vec("after_rst", 64'h0123456789ABCDEF, 64'hCC00CCFF_F0AAF0AA);
    drain();

    // Random traffic with random gaps and random back-pressure.
    rand_ready = 1;
    for (int n = 0; n < 1000; n++)
      send_block({$urandom, $urandom}, ($urandom_range(0, 3) == 0) ? 1 : 0);
    rand_ready = 0;
    bus.out_ready = 1;
    drain();
    chk("sb_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/des_ip_loader.md
Name: des_ip_loader

Overview:
- Input stage of the descrypt core; the counterpart of the core's final permutation (FP = IP^-1).
- Assembles 64-bit DES blocks from a narrow word stream and applies the DES initial permutation IP.
- Splits the result into L0/R0 halves and presents them to the round pipeline through a 2-entry buffered valid/ready interface.

Parameters:
WORD_WIDTH, 16, input beat width; legal values 8, 16, 32 (BEATS = 64/WORD_WIDTH).

Ports:
CLK  input  1  clock, all logic rising-edge.
RST  input  1  asynchronous, active-high reset.
in_flush  input  1  synchronous abort of a partially assembled block.
in_data  input  WORD_WIDTH  input beat; first beat of a block is the most significant word.
in_valid  input  1  in_data valid.
in_ready  output  1  loader can accept a beat.
out_l  output  32  L0 = IP(block)[63:32].
out_r  output  32  R0 = IP(block)[31:0].
out_valid  output  1  out_l/out_r valid.
out_ready  input  1  downstream accepts the current output.
partial  output  1  assembly in progress (beat counter != 0).

Behaviour:
- Bit convention: bit 63 = DES bit 1. For r,c in 0..7 and a = {24,56,16,48,8,40,0,32}[c], IP(x)[r + a] = x[63 - 8r - c].
- IP is the exact inverse of the core's FP: FP(IP(x)) == x for all x.
- Reset: beat counter = 0, FIFO empty, out_valid = 0, partial = 0, in_ready = 1, out_l = out_r = 0.
- Beat accept when in_valid && in_ready. Beat k (0-based) is stored at bits [63-k*WORD_WIDTH -: WORD_WIDTH] of the assembly register. Counter wraps BEATS-1 -> 0.
- On accept of the last beat, IP(assembled word including this beat) is written into the output FIFO in the same edge. No extra stage.
- Latency: last beat accepted at edge N with FIFO empty -> out_valid = 1 after edge N, data valid in that cycle.
- Output FIFO: depth 2, registered outputs, in order. Pop when out_valid && out_ready.
- Push and pop in the same cycle are both performed; count is unchanged.
- in_ready = (fifo_count != 2). It is registered or derived from count only; there is no combinational path from out_ready or in_valid.
- When full, in_ready = 0 for every beat, including non-last beats.
- out_l/out_r hold stable while out_valid && !out_ready. Values are don't-care when out_valid = 0, but must not glitch X after reset.
- in_flush: counter returns to 0 and the assembly register contents are don't-care.
  - FIFO contents and outputs are unaffected.
  - A beat presented in the same cycle as in_flush is discarded (flush wins).
  - in_ready is not affected by in_flush.
- partial = (counter != 0).
- RST asserted mid-block or with the FIFO occupied: everything returns to reset values immediately (async). Partial and buffered blocks are lost.
- in_data is sampled only on accept. in_valid with in_ready = 0 has no effect.

Test Plan:
- WORD_WIDTH=16, beats 0x0123,0x4567,0x89AB,0xCDEF with out_ready=1 -> one cycle after the 4th accept: out_valid=1, out_l=0xCC00CCFF, out_r=0xF0AAF0AA.
- Blocks 0x0000000000000000 and 0xFFFFFFFFFFFFFFFF -> (0,0) and (0xFFFFFFFF,0xFFFFFFFF). Feed 1000 random blocks through a software FP model -> FP({out_l,out_r}) equals the input block every time.
- out_ready=0, stream 3 blocks back-to-back -> in_ready falls after the 2nd block's last beat and the first beat of the 3rd is stalled. Raise out_ready -> outputs in order A,B,C, none lost or duplicated. Count/pop simultaneity is checked when count=2.
- Send 2 beats, assert in_flush together with a 3rd beat, then send 4 fresh beats -> exactly one output, equal to IP(fresh block). partial goes 1 -> 0 on flush.
- Assert RST asynchronously mid-block with 1 entry buffered -> out_valid=0, partial=0, in_ready=1 without waiting for CLK. The next full block is emitted correctly.
- Repeat the first scenario with WORD_WIDTH=8 (8 beats) and 32 (2 beats) -> identical out_l/out_r.
